// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the RV32I core, directly upstream of instr_mem.
// Owns the PC, drives it combinationally as the byte address into instr_mem,
// and captures the returned word together with its PC into a small FIFO.
// The FIFO head is handed to decode as {if_pc, if_instr} over valid/ready.
// Branch/jump redirects from execute reload the PC and flush the FIFO.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bits [1:0] != 0 flushes, raises
//               misalign and parks the stage in FAULT (no fetching) until an
//               aligned redirect arrives.
//   undefined : target bits [1:0] are silently cleared, misalign is tied 0,
//               FAULT is never entered.
//
// Parameters
//   ADDR_W    imem byte-address width; PC wraps modulo 2**ADDR_W
//   DEPTH     fetch FIFO entries (power of 2, >= 2)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   fetch_en     in   1 = fetch permitted; 0 = hold PC, no pushes
//   r_addr_imem  out  byte address to instr_mem (= pc)
//   r_data_imem  in   instruction word from instr_mem, same cycle
//   redirect     in   1-cycle pulse: load redirect_pc, flush FIFO
//   redirect_pc  in   redirect target; bits [ADDR_W-1:0] are used
//   if_valid     out  FIFO head holds a valid instruction
//   if_ready     in   decode accepts the head this cycle
//   if_instr     out  head instruction word (0 when empty)
//   if_pc        out  head PC, zero-extended (0 when empty)
//   misalign     out  misaligned-target fault flag
//   state_dbg    out  FSM state (0 = RUN, 1 = FAULT)
//
// Handshake: a word transfers to decode on every rising edge where
// if_valid && if_ready are both high and redirect is low. While if_valid is
// high and no transfer has happened, if_pc/if_instr hold steady. A redirect
// drops the head even if if_ready is high.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] r_addr_imem,
    input  logic [31:0]       r_data_imem,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic              misalign,
    output logic              state_dbg
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [ADDR_W-1:0] RESET_PC_RAW = ADDR_W'(RESET_PC);
    // PC is always kept word aligned.
    localparam logic [ADDR_W-1:0] RESET_PC_A   = {RESET_PC_RAW[ADDR_W-1:2], 2'b00};
    localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target_pc;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [31:0]       mem_instr [DEPTH];

    logic push, pop;
    logic target_misaligned;

    // Upper target bits beyond the imem window are intentionally ignored.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^{redirect_pc[31:ADDR_W], redirect_pc[1:0]};

    assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_misaligned = |redirect_pc[1:0];
`else
    assign target_misaligned = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Handshake and FIFO control
    // -------------------------------------------------------------------------
    assign if_valid = (count_q != '0);

    // Redirect wins over both sides of the FIFO.
    assign pop  = if_valid & if_ready & ~redirect;
    // A full FIFO may still accept a word when the head leaves the same cycle.
    assign push = (state_q == ST_RUN) & fetch_en & ~redirect &
                  ((count_q < DEPTH_C) | pop);

    assign r_addr_imem = pc_q;

    // Head is read straight from registered storage; outputs read as zero
    // whenever nothing valid is held.
    assign if_instr = if_valid ? mem_instr[head_q]   : 32'd0;
    assign if_pc    = if_valid ? 32'(mem_pc[head_q]) : 32'd0;

    // -------------------------------------------------------------------------
    // FSM: RUN fetches; FAULT parks after a misaligned target
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = target_misaligned ? ST_FAULT : ST_RUN;
        end
    end

    assign state_dbg = (state_q == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (redirect) begin
            misalign <= target_misaligned;
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // PC
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_A;
        end else if (redirect) begin
            pc_q <= target_pc;
        end else if (push) begin
            // Natural wrap modulo 2**ADDR_W.
            pc_q <= pc_q + ADDR_W'(4);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (redirect) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (push) begin
                tail_q <= (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail_q]    <= pc_q;
            mem_instr[tail_q] <= r_data_imem;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 2;
    localparam int RESET_PC = 0;
    localparam int PC_MOD = 1 << ADDR_W;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] r_addr_imem;
    logic [31:0]       r_data_imem;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_pc = 32'd0;
    logic              if_valid;
    logic              if_ready = 1'b0;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              misalign;
    logic              state_dbg;

    fetch_stage #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .r_addr_imem (r_addr_imem),
        .r_data_imem (r_data_imem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .misalign    (misalign),
        .state_dbg   (state_dbg)
    );

    // Instruction memory contents: a fixed function of the byte address.
    function automatic logic [31:0] imem_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8'hC3, b, ~b, b + 8'd3};
    endfunction

    always_comb r_data_imem = imem_word(int'(r_addr_imem));

    // ---------------------------------------------------------------- scoreboard
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] exp_q[$];     // expected instruction words, head first
    logic [31:0] exp_pc_q[$];  // matching PCs
    int          m_pc;
    bit          m_mis;
    bit          m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc_q.delete();
        m_pc    = RESET_PC & (PC_MOD - 4);
        m_mis   = 1'b0;
        m_fault = 1'b0;
    endtask

    // Behavioural model of one clock edge, driven by the current inputs.
    task automatic model_edge();
        bit do_pop, do_push;
        if (redirect) begin
            exp_q.delete();
            exp_pc_q.delete();
            m_pc = int'(redirect_pc) & (PC_MOD - 4);
`ifdef FETCH_MISALIGN_TRAP_EN
            m_mis   = (redirect_pc[1:0] != 2'b00);
            m_fault = m_mis;
`endif
        end else begin
            do_pop  = (exp_q.size() > 0) && if_ready;
            do_push = !m_fault && fetch_en && ((exp_q.size() < DEPTH) || do_pop);
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back(imem_word(m_pc));
                exp_pc_q.push_back(32'(m_pc));
                m_pc = (m_pc + 4) % PC_MOD;
            end
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("addr", 32'(r_addr_imem), 32'(m_pc));
            check("valid", 32'(if_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("instr", if_instr, exp_q[0]);
                check("pc", if_pc, exp_pc_q[0]);
            end else begin
                check("instr_empty", if_instr, 32'd0);
                check("pc_empty", if_pc, 32'd0);
            end
            check("misalign", 32'(misalign), 32'(m_mis));
            check("state", 32'(state_dbg), 32'(m_fault));
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic step(input logic fen, input logic rdy, input logic red, input logic [31:0] rpc);
        fetch_en    = fen;
        if_ready    = rdy;
        redirect    = red;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge();
        #1;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        redirect = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        model_reset();
        #12;
        // Reset values while rst_n is low.
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_addr", 32'(r_addr_imem), 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;

        // 1. streaming: if_pc = 0,4,8,...
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            check("stream_pc", if_pc, 32'(4 * (k - 1)));
        end
        check("stream_word", if_instr, 32'hC314EB17);

        // 2. backpressure: exactly DEPTH words buffered, pc holds at 8.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("bp_addr", 32'(r_addr_imem), 32'd8);
        check("bp_head", if_pc, 32'd0);
        check("bp_valid", 32'(if_valid), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("bp_rel1", if_pc, 32'd4);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("bp_rel2", if_pc, 32'd8);

        // 3. wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'd124);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap_addr", 32'(r_addr_imem), 32'd0);
        check("wrap_head", if_pc, 32'd124);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap_pc", if_pc, 32'd0);

        // 4. redirect while full flushes the old words.
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h40);
        check("redir_flush", 32'(if_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("redir_valid", 32'(if_valid), 32'd1);
        check("redir_pc", if_pc, 32'h40);

        // 5. misaligned target.
        step(1'b1, 1'b1, 1'b1, 32'h42);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_novalid", 32'(if_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h10);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("mis_clear", 32'(misalign), 32'd0);
        check("mis_resume", if_pc, 32'h10);
`else
        check("mis_tied", 32'(misalign), 32'd0);
        check("mis_resume", if_pc, 32'h44);
`endif

        // 6. async reset mid-stream with FIFO non-empty.
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_addr", 32'(r_addr_imem), 32'(RESET_PC));
        check("arst_pc", if_pc, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            step(logic'($urandom_range(0, 9) < 8),
                 logic'($urandom_range(0, 9) < 7),
                 logic'($urandom_range(0, 19) == 0),
                 $urandom());
        end

        // Final drain so the last state is compared.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
